// File: rtl/zombie_spawner_if.sv
// Spawn request channel: lane/type payload with valid/ready handshake.
interface zombie_spawner_if;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic       spawn_type;
  logic       spawn_ready;

  modport master (output spawn_valid, spawn_lane, spawn_type, input spawn_ready);
  modport slave  (input spawn_valid, spawn_lane, spawn_type, output spawn_ready);
endinterface

// File: rtl/zombie_spawner.sv
// Spawn scheduler: counts cur_interval ticks, picks a free lane one clk before raising valid,
// and holds lane/type stable until accepted; completed waves shorten the interval after a gap.
module zombie_spawner #(
  parameter int LANES         = 4,
  parameter int INIT_INTERVAL = 16,
  parameter int MIN_INTERVAL  = 4,
  parameter int INTERVAL_STEP = 2,
  parameter int WAVE_SIZE     = 8,
  parameter int GAP_TICKS     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             game_run,
  input  logic [3:0]       rand_val,
  input  logic [LANES-1:0] lane_busy,
  zombie_spawner_if.master spawn,
  output logic [3:0]       wave_num,
  output logic             wave_done
);
  localparam logic [7:0] INIT_W = 8'(INIT_INTERVAL);
  localparam logic [7:0] MIN_W  = 8'(MIN_INTERVAL);
  localparam logic [7:0] STEP_W = 8'(INTERVAL_STEP);
  localparam logic [7:0] WAVE_W = 8'(WAVE_SIZE);
  localparam logic [7:0] GAP_W  = 8'(GAP_TICKS);

  typedef enum logic [2:0] {IDLE, WAIT, PICK, ISSUE, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] cur_interval, cur_interval_nxt, next_interval;
  logic [7:0] spawned, spawned_nxt;
  logic [3:0] wave_num_nxt;
  logic [1:0] lane_q, lane_nxt, pick_lane;
  logic       type_q, type_nxt, wave_done_nxt, found;
  logic       unused_rand_bit;

  assign unused_rand_bit = rand_val[2];

  // Scan from the far end back to the preferred lane so the last hit is the first free lane in order.
  always_comb begin
    found     = 1'b0;
    pick_lane = 2'd0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (!lane_busy[2'(rand_val[1:0] + 2'(k))]) begin
        found     = 1'b1;
        pick_lane = 2'(rand_val[1:0] + 2'(k));
      end
    end
  end

  assign next_interval = ({1'b0, cur_interval} >= ({1'b0, MIN_W} + {1'b0, STEP_W}))
                         ? cur_interval - STEP_W : MIN_W;

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    cur_interval_nxt = cur_interval;
    spawned_nxt      = spawned;
    wave_num_nxt     = wave_num;
    lane_nxt         = lane_q;
    type_nxt         = type_q;
    wave_done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (game_run) begin
          cnt_nxt   = cur_interval;
          state_nxt = WAIT;
        end
      end
      WAIT, GAP: begin
        if (tick) begin
          if (cnt == 8'd1) begin
            if (state == WAIT) begin
              state_nxt = PICK;
            end else begin
              cnt_nxt   = cur_interval;
              state_nxt = WAIT;
            end
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      PICK: begin
        if (found) begin
          lane_nxt  = pick_lane;
          type_nxt  = rand_val[3] & (wave_num >= 4'd2);
          state_nxt = ISSUE;
        end else begin
          cnt_nxt   = 8'd1;
          state_nxt = WAIT;
        end
      end
      ISSUE: begin
        if (spawn.spawn_ready) begin
          if (spawned + 8'd1 == WAVE_W) begin
            spawned_nxt      = 8'd0;
            wave_num_nxt     = (wave_num == 4'hF) ? wave_num : wave_num + 4'd1;
            cur_interval_nxt = next_interval;
            wave_done_nxt    = 1'b1;
            cnt_nxt          = GAP_W;
            state_nxt        = GAP;
          end else begin
            spawned_nxt = spawned + 8'd1;
            cnt_nxt     = cur_interval;
            state_nxt   = WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Pausing drops an unaccepted request but keeps wave progress.
    if (state != IDLE && !game_run) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      cur_interval <= INIT_W;
      spawned      <= 8'd0;
      wave_num     <= 4'd0;
      lane_q       <= 2'd0;
      type_q       <= 1'b0;
      wave_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cur_interval <= cur_interval_nxt;
      spawned      <= spawned_nxt;
      wave_num     <= wave_num_nxt;
      lane_q       <= lane_nxt;
      type_q       <= type_nxt;
      wave_done    <= wave_done_nxt;
    end
  end

  assign spawn.spawn_valid = (state == ISSUE);
  assign spawn.spawn_lane  = lane_q;
  assign spawn.spawn_type  = type_q;
endmodule
